// File: rtl/rob_commit_ctrl_pkg.sv
// rob_commit_ctrl_pkg: ROB sizing, entry layout and controller state encoding
package rob_commit_ctrl_pkg;
   localparam int ROB_DEPTH = 16;
   localparam int PS_WIDTH = 6;
   localparam int AS_WIDTH = 5;
   localparam int RAT_PS_WIDTH = PS_WIDTH;
   localparam int ROB_IDX_WIDTH = $clog2(ROB_DEPTH);
   typedef struct packed {
      logic [RAT_PS_WIDTH-1:0] pd;
      logic [4:0]              rd;
      logic                    ready;
   } rob_entry_t;
   localparam int ROB_DATA_WIDTH = $bits(rob_entry_t);
   typedef enum logic {RUN, SQUASH} rob_state_t;
endpackage

// File: rtl/rob_commit_ctrl.sv
// rob_commit_ctrl: in-order ROB allocate/writeback/retire control; ROB_FLUSH_EN adds flush with per-cycle squash return
module rob_commit_ctrl
   import rob_commit_ctrl_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     alloc_valid,
   output logic                     alloc_ready,
   input  logic [AS_WIDTH-1:0]      alloc_rd,
   input  logic [PS_WIDTH-1:0]      alloc_pd,
   output logic [ROB_IDX_WIDTH-1:0] alloc_idx,
   input  logic                     wb_valid,
   input  logic [ROB_IDX_WIDTH-1:0] wb_idx,
   output logic                     commit_valid,
   input  logic                     commit_ready,
   output logic [AS_WIDTH-1:0]      commit_rd,
   output logic [PS_WIDTH-1:0]      commit_pd,
   output logic [ROB_IDX_WIDTH:0]   count,
   output logic                     empty,
   output logic                     full
`ifdef ROB_FLUSH_EN
   ,
   input  logic                     flush,
   output logic                     squash_valid,
   output logic [PS_WIDTH-1:0]      squash_pd
`endif
);
   localparam int IW = ROB_IDX_WIDTH;
   localparam int PW = ROB_IDX_WIDTH + 1;
   logic [PW-1:0]        head, tail;
   logic [IW-1:0]        h_idx, t_idx;
   logic [ROB_DEPTH-1:0] vld;
   rob_entry_t           ent [ROB_DEPTH];
   logic                 busy, hold, do_alloc, do_wb, do_commit;
   assign h_idx = head[IW-1:0];
   assign t_idx = tail[IW-1:0];
   assign empty = head == tail;
   assign full = (head[IW] != tail[IW]) && (h_idx == t_idx);
   assign count = tail - head;
   assign alloc_idx = t_idx;
   assign alloc_ready = !full && !busy;
   assign commit_valid = !empty && ent[h_idx].ready && !busy;
   assign commit_rd = AS_WIDTH'(ent[h_idx].rd);
   assign commit_pd = PS_WIDTH'(ent[h_idx].pd);
`ifdef ROB_FLUSH_EN
   rob_state_t    state;
   logic [IW-1:0] l_idx;
   logic          last;
   assign l_idx = t_idx - IW'(1);
   assign last = (tail - PW'(1)) == head;
   assign busy = state == SQUASH;
   assign hold = busy || flush;
   assign squash_valid = busy;
   assign squash_pd = PS_WIDTH'(ent[l_idx].pd);
   // Flush walks the tail back one entry per cycle until it meets the head
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RUN;
      else state <= (state == RUN) ? ((flush && !empty) ? SQUASH : RUN) : (last ? RUN : SQUASH);
   end
`else
   assign busy = 1'b0;
   assign hold = 1'b0;
`endif
   // Writebacks to dead entries are dropped; a same-cycle allocation overrides a writeback to the tail slot
   assign do_alloc = alloc_valid && alloc_ready && !hold;
   assign do_wb = wb_valid && vld[wb_idx] && !hold;
   assign do_commit = commit_valid && commit_ready && !hold;
   // Entry storage and head/tail pointers; later writes in this block take priority
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head <= '0;
         tail <= '0;
         vld <= '0;
         for (int i = 0; i < ROB_DEPTH; i++) ent[i] <= rob_entry_t'({ROB_DATA_WIDTH{1'b0}});
      end else begin
         if (do_wb) ent[wb_idx].ready <= 1'b1;
         if (do_alloc) begin
            ent[t_idx] <= '{pd: RAT_PS_WIDTH'(alloc_pd), rd: 5'(alloc_rd), ready: 1'b0};
            vld[t_idx] <= 1'b1;
         end
         if (do_commit) begin
            ent[h_idx].ready <= 1'b0;
            vld[h_idx] <= 1'b0;
         end
`ifdef ROB_FLUSH_EN
         if (busy) begin
            ent[l_idx].ready <= 1'b0;
            vld[l_idx] <= 1'b0;
         end
`endif
         head <= head + PW'(do_commit);
         tail <= tail + PW'(do_alloc) - PW'(busy);
      end
   end
endmodule
